// File: rtl/stream_demux6.sv
// ----------------------------------------------------------------------------
// stream_demux6
//
// One-to-six stream distributor. A single producer offers one WIDTH-bit word
// per valid/ready handshake together with a 3-bit channel select. Selects
// 0..5 route the word into a one-entry registered buffer for that channel,
// each with its own valid/ready handshake towards an independent consumer.
// Selects 6 and 7 have no channel: the word is consumed, discarded and
// counted in a saturating drop counter.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_in_valid      producer offers a word on i_in_data / i_in_sel
//   o_in_ready      block accepts the offered word this cycle (combinational)
//   i_in_sel        destination channel 0..5, 6/7 = drop
//   i_in_data       word to route
//   o_out_valid     bit k: channel k buffer holds a word
//   i_out_ready     bit k: consumer k takes the word this cycle
//   o_out_data0..5  channel buffer contents
//   o_drop_count    number of dropped words, saturating
// ----------------------------------------------------------------------------
module stream_demux6 #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_in_sel,
    input  logic [WIDTH-1:0]  i_in_data,
    output logic [5:0]        o_out_valid,
    input  logic [5:0]        i_out_ready,
    output logic [WIDTH-1:0]  o_out_data0,
    output logic [WIDTH-1:0]  o_out_data1,
    output logic [WIDTH-1:0]  o_out_data2,
    output logic [WIDTH-1:0]  o_out_data3,
    output logic [WIDTH-1:0]  o_out_data4,
    output logic [WIDTH-1:0]  o_out_data5,
    output logic [DROP_W-1:0] o_drop_count
);

    localparam int unsigned NumCh = 6;

    // Channel buffers and drop counter.
    logic [WIDTH-1:0]  r_data [NumCh];
    logic [NumCh-1:0]  r_valid;
    logic [DROP_W-1:0] r_drop_count;

    // Handshake decode.
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_drop;
    logic [NumCh-1:0]  w_load;
    logic [NumCh-1:0]  w_take;

    // ------------------------------------------------------------------------
    // Input-side ready. A channel can accept when its buffer is empty or is
    // being emptied this same cycle, which gives one word per cycle even to a
    // single channel. Drop selects always accept. i_in_valid is deliberately
    // not an input here so the producer sees ready without a loop through it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b1;
        case (i_in_sel)
            3'd0:    w_in_ready = ~r_valid[0] | i_out_ready[0];
            3'd1:    w_in_ready = ~r_valid[1] | i_out_ready[1];
            3'd2:    w_in_ready = ~r_valid[2] | i_out_ready[2];
            3'd3:    w_in_ready = ~r_valid[3] | i_out_ready[3];
            3'd4:    w_in_ready = ~r_valid[4] | i_out_ready[4];
            3'd5:    w_in_ready = ~r_valid[5] | i_out_ready[5];
            default: w_in_ready = 1'b1;
        endcase
    end

    assign w_in_fire = i_in_valid & w_in_ready;
    assign w_drop    = w_in_fire & i_in_sel[2] & i_in_sel[1];

    // Per-channel load/take strobes.
    always_comb begin
        w_load = '0;
        w_take = '0;
        for (int k = 0; k < NumCh; k++) begin
            w_load[k] = w_in_fire & (i_in_sel == 3'(k));
            w_take[k] = r_valid[k] & i_out_ready[k];
        end
    end

    // ------------------------------------------------------------------------
    // Channel buffers. A load wins over a take so a same-cycle take+load keeps
    // valid high with the new word. Data is only written on load, so it stays
    // stable while the consumer stalls and holds its last value once taken.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_valid[g] <= 1'b0;
                r_data[g]  <= '0;
            end else if (w_load[g]) begin
                r_valid[g] <= 1'b1;
                r_data[g]  <= i_in_data;
            end else if (w_take[g]) begin
                r_valid[g] <= 1'b0;
            end
        end
    end

    // Saturating drop counter; it never wraps back to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != {DROP_W{1'b1}})) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: everything except o_in_ready comes straight from registers.
    // ------------------------------------------------------------------------
    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = r_valid;
    assign o_out_data0  = r_data[0];
    assign o_out_data1  = r_data[1];
    assign o_out_data2  = r_data[2];
    assign o_out_data3  = r_data[3];
    assign o_out_data4  = r_data[4];
    assign o_out_data5  = r_data[5];
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_stream_demux6.sv
// ----------------------------------------------------------------------------
// tb_stream_demux6
//
// Self-checking bench for stream_demux6 (WIDTH=4, DROP_W=2 so saturation is
// reachable). A behavioural model of six one-word buffers plus a saturating
// drop count is advanced once per clock; scenario tasks compare the DUT to it.
// Inputs are driven at the falling edge, outputs sampled before the rising
// edge (o_in_ready) and one falling edge after it (registered outputs).
// ----------------------------------------------------------------------------
module tb_stream_demux6;

    localparam int unsigned W    = 4;
    localparam int unsigned DW   = 2;
    localparam int unsigned DMAX = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_sel;
    logic [W-1:0]  in_data;
    logic [5:0]    out_valid;
    logic [5:0]    out_ready;
    logic [W-1:0]  out_data0, out_data1, out_data2, out_data3, out_data4, out_data5;
    logic [DW-1:0] drop_count;

    int n_vec;
    int n_err;

    // Reference model state.
    bit        m_full [6];
    bit [W-1:0] m_word [6];
    int        m_drops;

    stream_demux6 #(
        .WIDTH  (W),
        .DROP_W (DW)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_sel     (in_sel),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data0  (out_data0),
        .o_out_data1  (out_data1),
        .o_out_data2  (out_data2),
        .o_out_data3  (out_data3),
        .o_out_data4  (out_data4),
        .o_out_data5  (out_data5),
        .o_drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] dut_data(int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            3:       return out_data3;
            4:       return out_data4;
            default: return out_data5;
        endcase
    endfunction

    // A word can enter channel k when the buffer is empty or drained this cycle.
    function automatic bit model_ready(logic [2:0] sel, logic [5:0] rdy);
        int s;
        s = int'(sel);
        if (s >= 6) return 1'b1;
        return !m_full[s] || rdy[s];
    endfunction

    function automatic logic [5:0] model_valid();
        logic [5:0] v;
        for (int k = 0; k < 6; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic drive(input bit rst, input bit v, input int sel, input int data,
                         input logic [5:0] rdy);
        reset     = rst;
        in_valid  = v;
        in_sel    = 3'(sel);
        in_data   = W'(data);
        out_ready = rdy;
        #1;
    endtask

    // Advance one clock and move the model according to the offered inputs.
    task automatic tick();
        bit fire;
        int s;
        fire = in_valid && model_ready(in_sel, out_ready);
        s    = int'(in_sel);
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 6; k++) begin
                m_full[k] = 1'b0;
                m_word[k] = '0;
            end
            m_drops = 0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (fire && s == k) begin
                    m_full[k] = 1'b1;
                    m_word[k] = in_data;
                end else if (m_full[k] && out_ready[k]) begin
                    m_full[k] = 1'b0;
                end
            end
            if (fire && s >= 6 && m_drops < DMAX) m_drops++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 0, 6'h3f);
        tick();
        drive(1'b0, 1'b0, 0, 0, 6'h3f);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_vec++;
        if (out_valid !== 6'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 000000", out_valid);
        end
        n_vec++;
        if (drop_count !== '0) begin
            n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count);
        end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (dut_data(k) !== '0) begin
                n_err++; $display("FAIL reset_data%0d: got %h want 0", k, dut_data(k));
            end
        end
        for (int s = 0; s < 8; s++) begin
            drive(1'b0, 1'b0, s, 0, 6'h00);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_ready sel%0d: got %b want 1", s, in_ready);
            end
        end
    endtask

    task automatic test_routing();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, k, k + 1, 6'h3f);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL route_ready%0d: got %b want 1", k, in_ready);
            end
            tick();
            n_vec++;
            if (out_valid !== 6'(1 << k)) begin
                n_err++; $display("FAIL route_valid%0d: got %b want %b", k, out_valid, 6'(1 << k));
            end
            n_vec++;
            if (dut_data(k) !== W'(k + 1)) begin
                n_err++; $display("FAIL route_data%0d: got %h want %h", k, dut_data(k), W'(k + 1));
            end
        end
        drive(1'b0, 1'b0, 0, 0, 6'h3f);
        tick();
        n_vec++;
        if (out_valid !== 6'b0 || drop_count !== '0) begin
            n_err++; $display("FAIL route_idle: valid %b drop %0d want 000000/0", out_valid, drop_count);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b1, 2, 'hA, 6'b111011);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_acceptA: got %b want 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 4'hA) begin
            n_err++; $display("FAIL bp_holdA: valid %b data %h want 1/a", out_valid[2], out_data2);
        end
        drive(1'b0, 1'b1, 2, 'hB, 6'b111011);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_blockB: got %b want 0", in_ready);
        end
        tick();
        n_vec++;
        if (out_data2 !== 4'hA) begin
            n_err++; $display("FAIL bp_stableA: got %h want a", out_data2);
        end
        drive(1'b0, 1'b1, 4, 'hC, 6'b111011);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_otherC: got %b want 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_data4 !== 4'hC || out_valid[4] !== 1'b1 || out_data2 !== 4'hA) begin
            n_err++; $display("FAIL bp_deliverC: d4 %h v4 %b d2 %h want c/1/a",
                              out_data4, out_valid[4], out_data2);
        end
        drive(1'b0, 1'b1, 2, 'hB, 6'h3f);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_releaseB: got %b want 1", in_ready);
        end
        tick();
        n_vec++;
        if (out_data2 !== 4'hB || out_valid[2] !== 1'b1) begin
            n_err++; $display("FAIL bp_deliverB: data %h valid %b want b/1", out_data2, out_valid[2]);
        end
        drive(1'b0, 1'b0, 0, 0, 6'h3f);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 5, i, 6'h3f);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
            end
            tick();
            n_vec++;
            if (out_data5 !== W'(i) || out_valid[5] !== 1'b1) begin
                n_err++; $display("FAIL b2b_data%0d: data %h valid %b want %h/1",
                                  i, out_data5, out_valid[5], W'(i));
            end
        end
        drive(1'b0, 1'b0, 0, 0, 6'h3f);
        tick();
    endtask

    task automatic test_drop();
        int want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0) ? 6 : 7, i, 6'h3f);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL drop_ready%0d: got %b want 1", i, in_ready);
            end
            tick();
            want = (i + 1 > 3) ? 3 : i + 1;
            n_vec++;
            if (drop_count !== DW'(want) || out_valid !== 6'b0) begin
                n_err++; $display("FAIL drop_count%0d: count %0d valid %b want %0d/000000",
                                  i, drop_count, out_valid, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b0, 1'b1, 1, 5, 6'h00); tick();
        drive(1'b0, 1'b1, 3, 9, 6'h00); tick();
        drive(1'b0, 1'b1, 6, 0, 6'h00); tick();
        drive(1'b0, 1'b1, 7, 0, 6'h00); tick();
        n_vec++;
        if (out_valid !== 6'b001010 || drop_count !== 2'd2) begin
            n_err++; $display("FAIL mid_fill: valid %b drop %0d want 001010/2", out_valid, drop_count);
        end
        // A word offered while reset is high must be neither accepted nor counted.
        drive(1'b1, 1'b1, 6, 0, 6'h00);
        tick();
        drive(1'b0, 1'b0, 0, 0, 6'h00);
        n_vec++;
        if (out_valid !== 6'b0 || out_data1 !== '0 || out_data3 !== '0 || drop_count !== '0) begin
            n_err++; $display("FAIL mid_reset: valid %b d1 %h d3 %h drop %0d want 0/0/0/0",
                              out_valid, out_data1, out_data3, drop_count);
        end
    endtask

    task automatic test_stall_independence();
        int ch;
        int d;
        do_reset();
        drive(1'b0, 1'b1, 0, 7, 6'b111110);
        tick();
        for (int i = 0; i < 10; i++) begin
            ch = 1 + (i % 5);
            d  = int'($urandom_range(0, 15));
            drive(1'b0, 1'b1, ch, d, 6'b111110);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL stall_ready%0d: got %b want 1", i, in_ready);
            end
            tick();
            n_vec++;
            if (dut_data(ch) !== W'(d) || out_valid[ch] !== 1'b1 ||
                out_data0 !== 4'h7 || out_valid[0] !== 1'b1) begin
                n_err++; $display("FAIL stall_ch%0d: d %h v %b d0 %h v0 %b want %h/1/7/1",
                                  ch, dut_data(ch), out_valid[ch], out_data0, out_valid[0], W'(d));
            end
        end
        drive(1'b0, 1'b0, 0, 0, 6'b111110);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_ready0: got %b want 0", in_ready);
        end
    endtask

    task automatic test_random();
        bit hold_v;
        int sel;
        int data;
        bit rst;
        bit v;
        hold_v = 1'b0;
        sel    = 0;
        data   = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            // Keep an unaccepted word stable, as a compliant producer would.
            if (!hold_v) begin
                v    = ($urandom_range(0, 3) != 0);
                sel  = int'($urandom_range(0, 7));
                data = int'($urandom_range(0, 15));
            end else begin
                v = 1'b1;
            end
            drive(rst, v, sel, data, 6'($urandom));
            n_vec++;
            if (in_ready !== model_ready(in_sel, out_ready)) begin
                n_err++; $display("FAIL rand_ready%0d: got %b want %b",
                                  i, in_ready, model_ready(in_sel, out_ready));
            end
            hold_v = v && !rst && !model_ready(in_sel, out_ready);
            tick();
            n_vec++;
            if (out_valid !== model_valid() || drop_count !== DW'(m_drops)) begin
                n_err++; $display("FAIL rand_state%0d: valid %b drop %0d want %b/%0d",
                                  i, out_valid, drop_count, model_valid(), m_drops);
            end
            for (int k = 0; k < 6; k++) begin
                n_vec++;
                if (dut_data(k) !== m_word[k]) begin
                    n_err++; $display("FAIL rand_data%0d ch%0d: got %h want %h",
                                      i, k, dut_data(k), m_word[k]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < 6; k++) begin
            m_full[k] = 1'b0;
            m_word[k] = '0;
        end
        m_drops = 0;
        drive(1'b1, 1'b0, 0, 0, 6'h3f);
        @(negedge clk);
        test_reset();
        test_routing();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_stall_independence();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux6.md
# stream_demux6

One-to-six stream distributor: the inverse of the 6:1 case-select mux. It accepts one WIDTH-bit word per handshake together with a 3-bit channel select, and delivers the word to the selected output channel through a one-entry registered buffer with valid/ready flow control. Selects 3'b110 and 3'b111 have no channel: the word is consumed, discarded and counted. The block sits between a single producer and six independent consumers in the datapath.

## Interface
- WIDTH, 4, data word width (bits)
- DROP_W, 8, width of the drop counter

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  input  1  producer has a word on in_data/in_sel
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  3  destination channel, 0..5 valid; 6, 7 = drop
- in_data  input  WIDTH  word to route
- out_valid  output  6  bit k: channel k buffer holds a word
- out_ready  input  6  bit k: consumer k takes the word this cycle
- out_data0..out_data5  output  WIDTH each  channel k buffer contents
- drop_count  output  DROP_W  number of words dropped (sel 6/7), saturating

## Operation
- Accept: in_fire = in_valid & in_ready.
- in_ready (combinational): sel 0..5 → !out_valid[sel] | out_ready[sel]; sel 6/7 → 1. Depends only on in_sel, out_valid, out_ready, never on in_valid.
- Channel k, each cycle:
  - load = in_fire & (in_sel == k); take = out_valid[k] & out_ready[k].
  - load: out_data_k ← in_data, out_valid[k] ← 1 (regardless of take; a same-cycle take + load gives full throughput).
  - take & !load: out_valid[k] ← 0; out_data_k holds its last value.
  - neither: hold. out_data_k must stay stable while out_valid[k]=1 and out_ready[k]=0.
- Channels are independent: a stalled channel blocks only words addressed to it; in_ready for other selects is unaffected.
- Drop: in_fire & in_sel ≥ 6 → drop_count ← drop_count + 1, saturating at 2^DROP_W−1 (no wrap). No channel changes.
- in_valid with in_ready=0: nothing changes; producer must hold in_data/in_sel stable until accepted.

## Timing
- Reset (reset=1 at a rising edge): out_valid = 6'b0, all out_data_k = 0, drop_count = 0. in_ready after reset: 1 for every sel, since all buffers are empty.
- Reset mid-operation: buffered words are discarded; no out_valid asserts in the cycle after reset. A word offered during the reset cycle is not accepted and not counted.
- Latency: a word accepted at edge N appears on out_valid[k]/out_data_k after edge N (visible in cycle N+1).
- Throughput: one word per cycle to any channel whose consumer holds out_ready=1. This includes back-to-back words to the same channel.
- Simultaneous events: load and take on the same channel in one cycle → new word replaces the old one and valid stays 1. Words to different channels in consecutive cycles never interact.
- No combinational path from in_valid or in_data to any output. The only combinational paths are out_ready → in_ready and in_sel → in_ready.

## Test plan
- Reset then routing: reset 1 cycle; send sel=0..5 with data 4'h1..4'h6, all out_ready=1 → out_valid[k] pulses 1 cycle each, one cycle after acceptance, with out_data_k=k+1; drop_count=0.
- Backpressure: out_ready[2]=0; send sel=2 data 4'hA → accepted, out_valid[2]=1. Send sel=2 data 4'hB → in_ready=0, out_data2 stays 4'hA. Meanwhile sel=4 data 4'hC is accepted. Raise out_ready[2] → 4'hB accepted the same cycle, and out_data2=4'hB on the next cycle.
- Full throughput: out_ready[5]=1; 8 back-to-back words to sel=5, data 0..7 → in_ready stays 1 and out_data5 steps 0..7 on consecutive cycles.
- Drop and saturation: with DROP_W=2, send 5 words alternating sel=6/7 → in_ready=1 each cycle, drop_count reads 1,2,3,3,3, and out_valid stays 0.
- Reset mid-operation: fill channels 1 and 3 with out_ready=0 and drop_count=2, then pulse reset → cycle after: out_valid=0, out_data1=out_data3=0, drop_count=0.
- Stall independence: channel 0 stalled (full, out_ready[0]=0) for 10 cycles while words stream to channels 1..5 → all are delivered and channel 0 contents are unchanged.
